// File: rtl/trap_controller_pkg.sv
// Shared privilege, cause-code and CSR constants for the commit-stage trap sequencer.
// Also holds the sequencer state type and the exception cause helper.
package trap_controller_pkg;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam logic [4:0] EXC_ILLEGAL = 5'd2;
  localparam logic [4:0] EXC_ECALL_U = 5'd8;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    FIRE    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  // ECALL arrives as the U-mode code; the real code depends on the caller's privilege.
  function automatic logic [63:0] exc_cause(input logic [4:0] code, input logic [1:0] priv);
    logic [4:0] c;
    c = (code == EXC_ECALL_U) ? (code + {3'b000, priv}) : code;
    return {59'b0, c};
  endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Commit-side and privilege-side signal bundle of the trap sequencer.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface trap_controller_if #(
  parameter int REG_WIDTH = 64
);
  logic                 wb_valid;
  logic [REG_WIDTH-1:0] wb_pc;
  logic                 wb_exc_valid;
  logic [4:0]           wb_exc_code;
  logic [REG_WIDTH-1:0] wb_exc_tval;
  logic                 wb_is_mret;
  logic                 wb_is_sret;
  logic                 mem_busy;
  logic                 irq_meip;
  logic                 irq_msip;
  logic                 irq_mtip;
  logic [REG_WIDTH-1:0] mie_csr;
  logic                 mstatus_mie;
  logic [1:0]           curr_priv_mode;

  logic                 commit_kill;
  logic                 stall_commit;
  logic                 pipeline_flush;
  logic                 trap_en;
  logic [63:0]          trap_cause;
  logic [REG_WIDTH-1:0] trap_pc;
  logic [REG_WIDTH-1:0] trap_mtval;
  logic                 trap_is_ret;
  logic [1:0]           trap_ret_from_priv;

  modport slave (
    input  wb_valid, wb_pc, wb_exc_valid, wb_exc_code, wb_exc_tval,
           wb_is_mret, wb_is_sret, mem_busy, irq_meip, irq_msip, irq_mtip,
           mie_csr, mstatus_mie, curr_priv_mode,
    output commit_kill, stall_commit, pipeline_flush, trap_en, trap_cause,
           trap_pc, trap_mtval, trap_is_ret, trap_ret_from_priv
  );

  modport master (
    output wb_valid, wb_pc, wb_exc_valid, wb_exc_code, wb_exc_tval,
           wb_is_mret, wb_is_sret, mem_busy, irq_meip, irq_msip, irq_mtip,
           mie_csr, mstatus_mie, curr_priv_mode,
    input  commit_kill, stall_commit, pipeline_flush, trap_en, trap_cause,
           trap_pc, trap_mtval, trap_is_ret, trap_ret_from_priv
  );
endinterface

// File: rtl/trap_controller_irq_prio_enc.sv
// Fixed-priority interrupt encoder: pending_i = {MEI, MSI, MTI}, MEI wins, then MSI, then MTI.
module irq_prio_enc
  import trap_controller_pkg::*;
(
  input  logic [2:0] pending_i,
  output logic       take_o,
  output logic [3:0] code_o
);

  always_comb begin
    take_o = |pending_i;
    code_o = 4'd0;
    if (pending_i[2])      code_o = IRQ_MEI;
    else if (pending_i[1]) code_o = IRQ_MSI;
    else if (pending_i[0]) code_o = IRQ_MTI;
  end

endmodule

// File: rtl/trap_controller.sv
// Commit-stage trap sequencer: picks the winning trap/xRET at commit, waits for memory to drain,
// strobes the privilege block for one cycle, then holds the pipeline flushed while fetch redirects.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int REG_WIDTH    = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input logic         clk,
  input logic         reset,
  trap_controller_if.slave trap_bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [63:0]          cause_q, cause_d;
  logic [REG_WIDTH-1:0] pc_q, pc_d;
  logic [REG_WIDTH-1:0] tval_q, tval_d;
  logic                 is_ret_q, is_ret_d;
  logic [1:0]           ret_priv_q, ret_priv_d;

  logic [2:0] pending;
  logic       irq_pend;
  logic [3:0] irq_code;
  logic       irq_take, exc_take, mret_take, sret_take, event_any;

  logic                 kill_o, stall_o, flush_o, trap_en_o, is_ret_o;
  logic [63:0]          cause_o;
  logic [REG_WIDTH-1:0] pc_o, tval_o;
  logic [1:0]           ret_priv_o;

  logic unused_mie;
  assign unused_mie = ^{trap_bus.mie_csr[REG_WIDTH-1:12], trap_bus.mie_csr[10:8],
                        trap_bus.mie_csr[6:4], trap_bus.mie_csr[2:0]};

  assign pending = {trap_bus.irq_meip & trap_bus.mie_csr[11],
                    trap_bus.irq_msip & trap_bus.mie_csr[3],
                    trap_bus.irq_mtip & trap_bus.mie_csr[7]};

  irq_prio_enc u_irq_prio_enc (
    .pending_i (pending),
    .take_o    (irq_pend),
    .code_o    (irq_code)
  );

  // Below M-mode interrupts are always globally enabled; in M-mode mstatus.MIE gates them.
  assign irq_take  = trap_bus.wb_valid & ((trap_bus.curr_priv_mode != PRIV_M) | trap_bus.mstatus_mie)
                     & irq_pend;
  assign exc_take  = trap_bus.wb_valid & trap_bus.wb_exc_valid;
  assign mret_take = trap_bus.wb_valid & trap_bus.wb_is_mret;
  assign sret_take = trap_bus.wb_valid & trap_bus.wb_is_sret;
  assign event_any = irq_take | exc_take | mret_take | sret_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cause_q    <= '0;
      pc_q       <= '0;
      tval_q     <= '0;
      is_ret_q   <= 1'b0;
      ret_priv_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      pc_q       <= pc_d;
      tval_q     <= tval_d;
      is_ret_q   <= is_ret_d;
      ret_priv_q <= ret_priv_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    pc_d       = pc_q;
    tval_d     = tval_q;
    is_ret_d   = is_ret_q;
    ret_priv_d = ret_priv_q;
    kill_o     = 1'b0;
    stall_o    = 1'b0;
    flush_o    = 1'b0;
    trap_en_o  = 1'b0;
    is_ret_o   = 1'b0;
    cause_o    = '0;
    pc_o       = '0;
    tval_o     = '0;
    ret_priv_o = 2'd0;

    unique case (state_q)
      IDLE: begin
        if (event_any) begin
          kill_o     = 1'b1;
          state_d    = trap_bus.mem_busy ? DRAIN : FIRE;
          pc_d       = trap_bus.wb_pc;
          cause_d    = '0;
          tval_d     = '0;
          is_ret_d   = 1'b0;
          ret_priv_d = 2'd0;
          if (irq_take) begin
            cause_d = {1'b1, 59'b0, irq_code};
          end else if (exc_take) begin
            cause_d = exc_cause(trap_bus.wb_exc_code, trap_bus.curr_priv_mode);
            tval_d  = trap_bus.wb_exc_tval;
          end else if (mret_take) begin
            is_ret_d   = 1'b1;
            ret_priv_d = PRIV_M;
          end else begin
            is_ret_d   = 1'b1;
            ret_priv_d = PRIV_S;
          end
        end
      end
      DRAIN: begin
        stall_o = 1'b1;
        if (!trap_bus.mem_busy) state_d = FIRE;
      end
      FIRE: begin
        stall_o    = 1'b1;
        flush_o    = 1'b1;
        trap_en_o  = ~is_ret_q;
        is_ret_o   = is_ret_q;
        cause_o    = cause_q;
        pc_o       = pc_q;
        tval_o     = tval_q;
        ret_priv_o = ret_priv_q;
        cnt_d      = CNT_LOAD;
        state_d    = RECOVER;
      end
      RECOVER: begin
        stall_o = 1'b1;
        flush_o = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign trap_bus.commit_kill        = kill_o;
  assign trap_bus.stall_commit       = stall_o;
  assign trap_bus.pipeline_flush     = flush_o;
  assign trap_bus.trap_en            = trap_en_o;
  assign trap_bus.trap_is_ret        = is_ret_o;
  assign trap_bus.trap_cause         = cause_o;
  assign trap_bus.trap_pc            = pc_o;
  assign trap_bus.trap_mtval         = tval_o;
  assign trap_bus.trap_ret_from_priv = ret_priv_o;

endmodule
